// File: rtl/usr_pkg.sv
// Types and defaults shared by the universal shift register slice and its benches.
package usr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } deser_state_t;

    localparam int USR_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register for assembled words.
// A word arriving while the buffer is full and not draining is dropped and flagged.
module deser_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             data_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun
);

    logic accept;

    // A drain in the same cycle frees the slot for the incoming word.
    assign accept = ~data_valid | data_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load && accept) begin
                data_out   <= word;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            if (load && !accept) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Reassembles a bit-serial stream into WIDTH-bit words, MSB- or LSB-first per frame.
//   state    | meaning
//   ST_IDLE  | waiting for a bit_en&sof to open a frame
//   ST_SHIFT | frame open, collecting bits 1..WIDTH-1
module serial_word_deserializer
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             ser_in,
    input  logic             sof,
    input  logic             msb_first,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int CW = $clog2(WIDTH + 1);

    deser_state_t     state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] captured;
    logic [WIDTH:0]   ext_msb;
    logic [WIDTH:0]   ext_lsb;
    logic [WIDTH:0]   cap_msb;
    logic [WIDTH:0]   cap_lsb;
    logic [CW-1:0]    bit_cnt;
    logic             frame_msb;
    logic             word_done;
    logic             bit_start;
    logic             frame_err_set;

    assign bit_start     = bit_en & sof;
    assign frame_err_set = (state == ST_SHIFT) & bit_start;
    assign busy          = (state == ST_SHIFT);

    // Widened vectors keep the shift expressions legal down to WIDTH==1.
    assign ext_msb  = {shreg, ser_in};
    assign ext_lsb  = {ser_in, shreg};
    assign cap_msb  = {WIDTH'(0), ser_in};
    assign cap_lsb  = {ser_in, WIDTH'(0)};
    assign shifted  = frame_msb ? ext_msb[WIDTH-1:0] : ext_lsb[WIDTH:1];
    assign captured = msb_first ? cap_msb[WIDTH-1:0] : cap_lsb[WIDTH:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_msb <= 1'b0;
            word_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bit_start) begin
                        shreg     <= captured;
                        frame_msb <= msb_first;
                        if (WIDTH == 1) begin
                            word_done <= 1'b1;
                            bit_cnt   <= '0;
                        end else begin
                            state   <= ST_SHIFT;
                            bit_cnt <= CW'(1);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bit_start) begin
                        shreg     <= captured;
                        frame_msb <= msb_first;
                        bit_cnt   <= CW'(1);
                    end else if (bit_en) begin
                        shreg <= shifted;
                        if (bit_cnt == CW'(WIDTH - 1)) begin
                            word_done <= 1'b1;
                            bit_cnt   <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (frame_err_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    // shreg holds the finished word during the word_done cycle, giving one
    // clock of latency from the last bit edge to data_valid.
    deser_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (word_done),
        .word       (shreg),
        .data_ready (data_ready),
        .clr_err    (clr_err),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench for serial_word_deserializer (WIDTH=4): vector table plus corner-case sequences.
module tb_serial_word_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bit_en = 1'b0;
    logic         ser_in = 1'b0;
    logic         sof = 1'b0;
    logic         msb_first = 1'b1;
    logic         data_ready = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        logic       msb;
        logic [3:0] bits;   // bits[3] is sent first
        int         gap;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    serial_word_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .ser_in     (ser_in),
        .sof        (sof),
        .msb_first  (msb_first),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        bit_en = 1'b1;
        ser_in = b;
        sof    = s;
        tick();
        bit_en = 1'b0;
        sof    = 1'b0;
    endtask

    task automatic send_frame(input logic msb, input logic [3:0] bits, input int gap);
        msb_first = msb;
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i], (i == 3));
            if (i != 0) repeat (gap) tick();
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk(name, sb.size(), 0);
    endtask

    // Scoreboard: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && data_valid && data_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got word %0h expected none", data_out);
            end else begin
                logic [W-1:0] e;
                e = sb.pop_front();
                chk("sb_word", data_out, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 4'b1011, 0, 4'hB};
        vecs[1] = '{1'b0, 4'b1011, 0, 4'hD};
        vecs[2] = '{1'b0, 4'b1011, 2, 4'hD};
        vecs[3] = '{1'b1, 4'b0110, 1, 4'h6};
        vecs[4] = '{1'b0, 4'b1000, 0, 4'h1};
        vecs[5] = '{1'b1, 4'b1000, 3, 4'h8};

        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        tick();

        // Stray bits and sof without bit_en in IDLE must not start a frame
        ser_in = 1'b1;
        bit_en = 1'b1;
        repeat (3) tick();
        bit_en = 1'b0;
        sof    = 1'b1;
        repeat (2) tick();
        sof    = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_valid", data_valid, 0);
        chk("idle_frame_err", frame_err, 0);

        data_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].msb, vecs[i].bits, vecs[i].gap);
            sb.push_back(vecs[i].exp);
            chk("vec_pre_valid", data_valid, 0);
            tick();
            chk("vec_valid", data_valid, 1);
            chk("vec_word", data_out, vecs[i].exp);
            tick();
            chk("vec_valid_pulse", data_valid, 0);
            chk("vec_busy", busy, 0);
        end
        wait_drain("vec_drain");

        // Overrun: second word dropped while buffer is full
        data_ready = 1'b0;
        send_frame(1'b1, 4'h3, 0);
        tick();
        chk("ovr_first_valid", data_valid, 1);
        send_frame(1'b1, 4'hC, 0);
        tick();
        chk("ovr_flag", overrun, 1);
        chk("ovr_data", data_out, 4'h3);
        chk("ovr_valid", data_valid, 1);
        sb.push_back(4'h3);
        data_ready = 1'b1;
        tick();
        chk("ovr_drained", data_valid, 0);
        chk("ovr_hold", data_out, 4'h3);
        chk("ovr_sticky", overrun, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovr_clear", overrun, 0);
        wait_drain("ovr_drain");

        // Drain and load in the same cycle
        data_ready = 1'b0;
        send_frame(1'b1, 4'h3, 0);
        tick();
        send_frame(1'b1, 4'hC, 0);
        sb.push_back(4'h3);
        sb.push_back(4'hC);
        data_ready = 1'b1;
        tick();
        chk("dl_data", data_out, 4'hC);
        chk("dl_valid", data_valid, 1);
        chk("dl_overrun", overrun, 0);
        wait_drain("dl_drain");

        // Framing error: sof arrives after two bits
        msb_first = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        chk("fr_busy", busy, 1);
        send_bit(1'b0, 1'b1);
        chk("fr_flag", frame_err, 1);
        chk("fr_still_busy", busy, 1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        sb.push_back(4'h6);
        tick();
        chk("fr_data", data_out, 4'h6);
        wait_drain("fr_drain");
        chk("fr_sticky", frame_err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("fr_clear", frame_err, 0);

        // New error in the same cycle as clr_err: set wins
        send_bit(1'b1, 1'b1);
        clr_err = 1'b1;
        send_bit(1'b0, 1'b1);
        clr_err = 1'b0;
        chk("fr_set_wins", frame_err, 1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        sb.push_back(4'h7);
        tick();
        chk("fr_restart_data", data_out, 4'h7);
        wait_drain("fr2_drain");
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Reset mid-frame with a word still buffered
        data_ready = 1'b0;
        send_frame(1'b1, 4'h5, 0);
        tick();
        chk("rs_buffered", data_valid, 1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        chk("rs_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_busy", busy, 0);
        chk("rs_valid", data_valid, 0);
        chk("rs_data", data_out, 0);
        chk("rs_overrun", overrun, 0);
        chk("rs_frame_err", frame_err, 0);
        data_ready = 1'b1;
        send_frame(1'b1, 4'hA, 0);
        sb.push_back(4'hA);
        tick();
        chk("rs_next_valid", data_valid, 1);
        chk("rs_next_data", data_out, 4'hA);
        wait_drain("rs_drain");
        chk("rs_frame_err_after", frame_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
